wb_priority_controller: RTL and testbench
=========================================

WB_PRIORITY_CONTROLLER -- requirements
Module: wb_priority_controller

Interface
REQ-001 Parameter NUM_UNITS, default 9, number of execution-unit requesters.
REQ-002 Parameter AGE_LIMIT, default 8, wait cycles before a requester becomes starved.
REQ-003 Parameter AGE_W, default 4, age-counter width; SHALL satisfy 2**AGE_W > AGE_LIMIT.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 unit_valid_i  input  NUM_UNITS  bit i set = unit i holds a completed result; index order is FDIV, FSQRT, R4, FMUL, FADD_SUB, DIV, MUL, FP, ALU (index 0 to 8).
REQ-007 wb_stall_i  input  1  downstream EXE/MEM register cannot accept this cycle.
REQ-008 flush_i  input  1  pipeline flush; discards all pending arbitration history.
REQ-009 p_sel_o  output  priority_t  select driving the writeback priority mux.
REQ-010 grant_o  output  NUM_UNITS  one-hot grant; unit i's result is consumed this cycle.
REQ-011 unit_stall_o  output  NUM_UNITS  bit i set = unit i valid but not granted; unit SHALL hold its result.
REQ-012 starved_o  output  1  a starvation override is active this cycle (debug).

Function
REQ-013 Grant SHALL be same-cycle (combinational from unit_valid_i and registered state); zero latency.
REQ-014 Normal mode: grant the valid unit with the lowest index (fixed priority per REQ-006).
REQ-015 Each unit SHALL own an age counter: increments (saturating at AGE_LIMIT) each cycle it is valid, not granted, and wb_stall_i=0; clears when granted or when its valid is low.
REQ-016 A unit whose counter equals AGE_LIMIT is starved; if any unit is starved, grant the starved unit at or after the round-robin pointer rr_ptr (wrapping at NUM_UNITS-1 to 0), overriding REQ-014, and assert starved_o.
REQ-017 rr_ptr SHALL advance to (granted index + 1) mod NUM_UNITS after each starvation-override grant; unchanged otherwise.
REQ-018 p_sel_o SHALL map the granted index to its priority_t value (FDIV_unit ... ALU_unit); no valid unit -> DEFAULT_unit.
REQ-019 wb_stall_i=1: grant_o SHALL be all-zero, unit_stall_o SHALL equal unit_valid_i, p_sel_o SHALL hold the last registered selection, and age counters and rr_ptr SHALL freeze.
REQ-020 flush_i=1: grant_o all-zero, p_sel_o=DEFAULT_unit, all age counters and rr_ptr cleared next cycle; flush has priority over wb_stall_i.
REQ-021 grant_o SHALL be one-hot or zero in every cycle; grant_o and unit_stall_o SHALL never overlap.
REQ-022 A grant SHALL be issued only to a unit with unit_valid_i set in that cycle.
REQ-023 Requester dropping valid mid-wait SHALL lose its accumulated age with no effect on others.

Reset
REQ-024 reset_n=0 at a rising edge: age counters=0, rr_ptr=0, last-selection register=DEFAULT_unit.
REQ-025 While reset_n=0: grant_o=0, unit_stall_o=0, starved_o=0, p_sel_o=DEFAULT_unit, regardless of inputs.
REQ-026 Reset asserted mid-starvation SHALL discard all ages; the first cycle after release arbitrates in normal mode.

Structure
REQ-027 priority_t and its enum values (including DEFAULT_unit) SHALL come from riscv_types; NUM_UNITS-to-priority_t index mapping SHALL be a constant array in riscv_types.
REQ-028 One sub-module, wb_age_counter (per-unit saturating counter), instantiated NUM_UNITS times via generate.
REQ-029 No latches; one always_ff block for state and one always_comb block for arbitration.

Verification
REQ-030 Single request: unit_valid_i=9'b1_0000_0000 (ALU) -> grant_o bit 8, p_sel_o=ALU_unit, same cycle.
REQ-031 Contention: FDIV and ALU both valid -> FDIV granted, unit_stall_o bit 8 = 1.
REQ-032 Starvation: ALU valid continuously, FMUL valid continuously, AGE_LIMIT=8 -> ALU granted in the 9th cycle with starved_o=1, rr_ptr=0 afterwards.
REQ-033 Stall: wb_stall_i=1 for 5 cycles with 3 units valid -> grant_o=0, ages unchanged, p_sel_o held; arbitration resumes on release.
REQ-034 Flush during a starvation window (ALU age=7) -> next cycle all ages 0, p_sel_o=DEFAULT_unit, FMUL wins on resume.
REQ-035 Reset mid-operation with all units valid -> outputs per REQ-025; after release, FDIV granted first.

Source files
------------

// File: rtl/riscv_types.sv
// Shared writeback types: the priority-mux select encoding and the
// requester-index to select mapping used by the writeback arbiter.
package riscv_types;

    typedef enum logic [3:0] {
        FDIV_unit     = 4'd0,
        FSQRT_unit    = 4'd1,
        R4_unit       = 4'd2,
        FMUL_unit     = 4'd3,
        FADD_SUB_unit = 4'd4,
        DIV_unit      = 4'd5,
        MUL_unit      = 4'd6,
        FP_unit       = 4'd7,
        ALU_unit      = 4'd8,
        DEFAULT_unit  = 4'd9
    } priority_t;

    localparam int UNIT_MAP_LEN = 9;

    localparam priority_t UNIT_PRIORITY [UNIT_MAP_LEN] = '{
        FDIV_unit, FSQRT_unit, R4_unit, FMUL_unit, FADD_SUB_unit,
        DIV_unit, MUL_unit, FP_unit, ALU_unit
    };

    // Requester indices beyond the table have no mux input, so they map to the idle select.
    function automatic priority_t index_to_priority(input int idx);
        if (idx >= 0 && idx < UNIT_MAP_LEN) begin
            return UNIT_PRIORITY[idx];
        end
        return DEFAULT_unit;
    endfunction

endpackage

// File: rtl/wb_age_counter.sv
// Per-requester wait-age counter: counts cycles spent waiting, saturating
// at the starvation threshold; clear wins over increment.
module wb_age_counter #(
    parameter int AGE_W     = 4,
    parameter int AGE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [AGE_W-1:0] age
);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            age <= '0;
        end else if (inc && age != AGE_W'(AGE_LIMIT)) begin
            age <= age + AGE_W'(1);
        end
    end

endmodule

// File: rtl/wb_priority_controller.sv
// Writeback arbiter: fixed priority by unit index, with an aging round-robin
// override that rescues requesters held off for AGE_LIMIT cycles.
module wb_priority_controller
    import riscv_types::*;
#(
    parameter int NUM_UNITS = 9,
    parameter int AGE_LIMIT = 8,
    parameter int AGE_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_UNITS-1:0] unit_valid_i,
    input  logic                 wb_stall_i,
    input  logic                 flush_i,
    output priority_t            p_sel_o,
    output logic [NUM_UNITS-1:0] grant_o,
    output logic [NUM_UNITS-1:0] unit_stall_o,
    output logic                 starved_o
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [AGE_W-1:0]     age [NUM_UNITS];
    logic [NUM_UNITS-1:0] starved_vec;
    logic [NUM_UNITS-1:0] age_clear;
    logic [NUM_UNITS-1:0] age_inc;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_ptr_next;
    priority_t            last_sel;
    priority_t            last_sel_next;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_age
        wb_age_counter #(
            .AGE_W    (AGE_W),
            .AGE_LIMIT(AGE_LIMIT)
        ) u_age (
            .clk    (clk),
            .reset_n(reset_n),
            .clear  (age_clear[g]),
            .inc    (age_inc[g]),
            .age    (age[g])
        );
        assign starved_vec[g] = unit_valid_i[g] && (age[g] == AGE_W'(AGE_LIMIT));
    end

    always_comb begin
        int  win;
        int  cand;
        int  nxt;
        logic found;
        logic override;

        grant_o       = '0;
        unit_stall_o  = '0;
        starved_o     = 1'b0;
        p_sel_o       = DEFAULT_unit;
        age_clear     = '0;
        age_inc       = '0;
        rr_ptr_next   = rr_ptr;
        last_sel_next = last_sel;
        win           = 0;
        cand          = 0;
        nxt           = 0;
        found         = 1'b0;
        override      = 1'b0;

        if (!reset_n) begin
            rr_ptr_next   = '0;
            last_sel_next = DEFAULT_unit;
        end else if (flush_i) begin
            unit_stall_o  = unit_valid_i;
            age_clear     = '1;
            rr_ptr_next   = '0;
            last_sel_next = DEFAULT_unit;
        end else if (wb_stall_i) begin
            unit_stall_o = unit_valid_i;
            p_sel_o      = last_sel;
        end else begin
            // Any starved requester pre-empts fixed priority; search starts at rr_ptr so starved units rotate fairly.
            if (|starved_vec) begin
                override = 1'b1;
                for (int k = 0; k < NUM_UNITS; k++) begin
                    cand = int'(rr_ptr) + k;
                    if (cand >= NUM_UNITS) begin
                        cand = cand - NUM_UNITS;
                    end
                    if (!found && starved_vec[cand[PTR_W-1:0]]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
            end else begin
                for (int i = NUM_UNITS - 1; i >= 0; i--) begin
                    if (unit_valid_i[i[PTR_W-1:0]]) begin
                        found = 1'b1;
                        win   = i;
                    end
                end
            end

            if (found) begin
                grant_o = {{(NUM_UNITS-1){1'b0}}, 1'b1} << win;
                p_sel_o = index_to_priority(win);
                if (override) begin
                    starved_o = 1'b1;
                    nxt = win + 1;
                    if (nxt >= NUM_UNITS) begin
                        nxt = 0;
                    end
                    rr_ptr_next = nxt[PTR_W-1:0];
                end
            end

            unit_stall_o  = unit_valid_i & ~grant_o;
            age_clear     = grant_o | ~unit_valid_i;
            age_inc       = unit_valid_i & ~grant_o;
            last_sel_next = p_sel_o;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            last_sel <= DEFAULT_unit;
        end else begin
            rr_ptr   <= rr_ptr_next;
            last_sel <= last_sel_next;
        end
    end

endmodule

// File: tb/tb_wb_priority_controller.sv
// Directed bench for the writeback arbiter: reset, fixed priority, aging
// override, stall hold, flush, valid drop and round-robin rotation.
module tb_wb_priority_controller;
    import riscv_types::*;

    logic       clk;
    logic       reset_n;
    logic [8:0] unit_valid;
    logic       wb_stall;
    logic       flush;
    priority_t  p_sel;
    logic [8:0] grant;
    logic [8:0] unit_stall;
    logic       starved;

    int checks;
    int errors;

    wb_priority_controller #(
        .NUM_UNITS(9),
        .AGE_LIMIT(8),
        .AGE_W    (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .unit_valid_i(unit_valid),
        .wb_stall_i  (wb_stall),
        .flush_i     (flush),
        .p_sel_o     (p_sel),
        .grant_o     (grant),
        .unit_stall_o(unit_stall),
        .starved_o   (starved)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs just after a rising edge, return at the falling edge to sample.
    task automatic drive_cycle(input logic rst_n, input logic [8:0] v, input logic st, input logic fl);
        @(posedge clk);
        #1;
        reset_n    = rst_n;
        unit_valid = v;
        wb_stall   = st;
        flush      = fl;
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            drive_cycle(1'b0, 9'h1FF, 1'b0, 1'b0);
            checks += 4;
            if (grant !== 9'h000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected %b", grant, 9'h000); end
            if (unit_stall !== 9'h000) begin errors++; $display("[TB] FAIL reset_unit_stall: got %b expected %b", unit_stall, 9'h000); end
            if (starved !== 1'b0) begin errors++; $display("[TB] FAIL reset_starved: got %b expected 0", starved); end
            if (p_sel !== DEFAULT_unit) begin errors++; $display("[TB] FAIL reset_p_sel: got %0d expected %0d", p_sel, DEFAULT_unit); end
        end
    endtask

    task automatic test_single;
        drive_cycle(1'b1, 9'h100, 1'b0, 1'b0);
        checks += 3;
        if (grant !== 9'h100) begin errors++; $display("[TB] FAIL single_grant: got %b expected %b", grant, 9'h100); end
        if (p_sel !== ALU_unit) begin errors++; $display("[TB] FAIL single_p_sel: got %0d expected %0d", p_sel, ALU_unit); end
        if (unit_stall !== 9'h000) begin errors++; $display("[TB] FAIL single_unit_stall: got %b expected %b", unit_stall, 9'h000); end
        drive_cycle(1'b1, 9'h000, 1'b0, 1'b0);
        checks += 2;
        if (grant !== 9'h000) begin errors++; $display("[TB] FAIL idle_grant: got %b expected %b", grant, 9'h000); end
        if (p_sel !== DEFAULT_unit) begin errors++; $display("[TB] FAIL idle_p_sel: got %0d expected %0d", p_sel, DEFAULT_unit); end
    endtask

    task automatic test_contention;
        drive_cycle(1'b1, 9'h101, 1'b0, 1'b0);
        checks += 3;
        if (grant !== 9'h001) begin errors++; $display("[TB] FAIL contention_grant: got %b expected %b", grant, 9'h001); end
        if (unit_stall !== 9'h100) begin errors++; $display("[TB] FAIL contention_unit_stall: got %b expected %b", unit_stall, 9'h100); end
        if (p_sel !== FDIV_unit) begin errors++; $display("[TB] FAIL contention_p_sel: got %0d expected %0d", p_sel, FDIV_unit); end
        drive_cycle(1'b1, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic test_starvation;
        logic [8:0] exp_grant;
        priority_t  exp_sel;
        for (int c = 1; c <= 10; c++) begin
            drive_cycle(1'b1, 9'h108, 1'b0, 1'b0);
            exp_grant = (c == 9) ? 9'h100 : 9'h008;
            exp_sel   = (c == 9) ? ALU_unit : FMUL_unit;
            checks += 4;
            if (grant !== exp_grant) begin errors++; $display("[TB] FAIL starve_grant cycle %0d: got %b expected %b", c, grant, exp_grant); end
            if (starved !== (c == 9)) begin errors++; $display("[TB] FAIL starve_flag cycle %0d: got %b expected %b", c, starved, (c == 9)); end
            if (p_sel !== exp_sel) begin errors++; $display("[TB] FAIL starve_p_sel cycle %0d: got %0d expected %0d", c, p_sel, exp_sel); end
            if (unit_stall !== (9'h108 & ~exp_grant)) begin errors++; $display("[TB] FAIL starve_unit_stall cycle %0d: got %b expected %b", c, unit_stall, 9'h108 & ~exp_grant); end
        end
        drive_cycle(1'b1, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        logic [8:0] exp_grant;
        drive_cycle(1'b1, 9'h10A, 1'b0, 1'b0);
        checks += 2;
        if (grant !== 9'h002) begin errors++; $display("[TB] FAIL prestall_grant: got %b expected %b", grant, 9'h002); end
        if (p_sel !== FSQRT_unit) begin errors++; $display("[TB] FAIL prestall_p_sel: got %0d expected %0d", p_sel, FSQRT_unit); end
        for (int c = 1; c <= 5; c++) begin
            drive_cycle(1'b1, 9'h10A, 1'b1, 1'b0);
            checks += 4;
            if (grant !== 9'h000) begin errors++; $display("[TB] FAIL stall_grant cycle %0d: got %b expected %b", c, grant, 9'h000); end
            if (unit_stall !== 9'h10A) begin errors++; $display("[TB] FAIL stall_unit_stall cycle %0d: got %b expected %b", c, unit_stall, 9'h10A); end
            if (p_sel !== FSQRT_unit) begin errors++; $display("[TB] FAIL stall_p_sel cycle %0d: got %0d expected %0d", c, p_sel, FSQRT_unit); end
            if (starved !== 1'b0) begin errors++; $display("[TB] FAIL stall_starved cycle %0d: got %b expected 0", c, starved); end
        end
        drive_cycle(1'b1, 9'h10A, 1'b0, 1'b0);
        checks += 1;
        if (grant !== 9'h002) begin errors++; $display("[TB] FAIL resume_grant: got %b expected %b", grant, 9'h002); end
        // ALU has aged only twice; a counter that ran during the stall would starve earlier.
        for (int c = 1; c <= 7; c++) begin
            drive_cycle(1'b1, 9'h108, 1'b0, 1'b0);
            exp_grant = (c == 7) ? 9'h100 : 9'h008;
            checks += 2;
            if (grant !== exp_grant) begin errors++; $display("[TB] FAIL frozen_age_grant cycle %0d: got %b expected %b", c, grant, exp_grant); end
            if (starved !== (c == 7)) begin errors++; $display("[TB] FAIL frozen_age_starved cycle %0d: got %b expected %b", c, starved, (c == 7)); end
        end
        drive_cycle(1'b1, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic test_flush;
        logic [8:0] exp_grant;
        for (int c = 1; c <= 7; c++) begin
            drive_cycle(1'b1, 9'h108, 1'b0, 1'b0);
            checks += 1;
            if (grant !== 9'h008) begin errors++; $display("[TB] FAIL preflush_grant cycle %0d: got %b expected %b", c, grant, 9'h008); end
        end
        drive_cycle(1'b1, 9'h108, 1'b1, 1'b1);
        checks += 3;
        if (grant !== 9'h000) begin errors++; $display("[TB] FAIL flush_grant: got %b expected %b", grant, 9'h000); end
        if (p_sel !== DEFAULT_unit) begin errors++; $display("[TB] FAIL flush_p_sel: got %0d expected %0d", p_sel, DEFAULT_unit); end
        if (starved !== 1'b0) begin errors++; $display("[TB] FAIL flush_starved: got %b expected 0", starved); end
        drive_cycle(1'b1, 9'h108, 1'b1, 1'b0);
        checks += 2;
        if (grant !== 9'h000) begin errors++; $display("[TB] FAIL postflush_stall_grant: got %b expected %b", grant, 9'h000); end
        if (p_sel !== DEFAULT_unit) begin errors++; $display("[TB] FAIL postflush_stall_p_sel: got %0d expected %0d", p_sel, DEFAULT_unit); end
        for (int c = 1; c <= 9; c++) begin
            drive_cycle(1'b1, 9'h108, 1'b0, 1'b0);
            exp_grant = (c == 9) ? 9'h100 : 9'h008;
            checks += 2;
            if (grant !== exp_grant) begin errors++; $display("[TB] FAIL postflush_grant cycle %0d: got %b expected %b", c, grant, exp_grant); end
            if (starved !== (c == 9)) begin errors++; $display("[TB] FAIL postflush_starved cycle %0d: got %b expected %b", c, starved, (c == 9)); end
        end
        drive_cycle(1'b1, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic test_valid_drop;
        logic [8:0] exp_grant;
        for (int c = 1; c <= 5; c++) begin
            drive_cycle(1'b1, 9'h108, 1'b0, 1'b0);
        end
        drive_cycle(1'b1, 9'h008, 1'b0, 1'b0);
        checks += 2;
        if (grant !== 9'h008) begin errors++; $display("[TB] FAIL drop_grant: got %b expected %b", grant, 9'h008); end
        if (unit_stall !== 9'h000) begin errors++; $display("[TB] FAIL drop_unit_stall: got %b expected %b", unit_stall, 9'h000); end
        for (int c = 1; c <= 9; c++) begin
            drive_cycle(1'b1, 9'h108, 1'b0, 1'b0);
            exp_grant = (c == 9) ? 9'h100 : 9'h008;
            checks += 2;
            if (grant !== exp_grant) begin errors++; $display("[TB] FAIL drop_regrow_grant cycle %0d: got %b expected %b", c, grant, exp_grant); end
            if (starved !== (c == 9)) begin errors++; $display("[TB] FAIL drop_regrow_starved cycle %0d: got %b expected %b", c, starved, (c == 9)); end
        end
        drive_cycle(1'b1, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        for (int c = 1; c <= 8; c++) begin
            drive_cycle(1'b1, 9'h108, 1'b0, 1'b0);
        end
        drive_cycle(1'b0, 9'h1FF, 1'b0, 1'b0);
        checks += 4;
        if (grant !== 9'h000) begin errors++; $display("[TB] FAIL midreset_grant: got %b expected %b", grant, 9'h000); end
        if (unit_stall !== 9'h000) begin errors++; $display("[TB] FAIL midreset_unit_stall: got %b expected %b", unit_stall, 9'h000); end
        if (starved !== 1'b0) begin errors++; $display("[TB] FAIL midreset_starved: got %b expected 0", starved); end
        if (p_sel !== DEFAULT_unit) begin errors++; $display("[TB] FAIL midreset_p_sel: got %0d expected %0d", p_sel, DEFAULT_unit); end
        drive_cycle(1'b1, 9'h108, 1'b0, 1'b0);
        checks += 2;
        if (grant !== 9'h008) begin errors++; $display("[TB] FAIL postreset_grant: got %b expected %b", grant, 9'h008); end
        if (starved !== 1'b0) begin errors++; $display("[TB] FAIL postreset_starved: got %b expected 0", starved); end
        drive_cycle(1'b0, 9'h1FF, 1'b0, 1'b0);
        drive_cycle(1'b1, 9'h1FF, 1'b0, 1'b0);
        checks += 3;
        if (grant !== 9'h001) begin errors++; $display("[TB] FAIL allvalid_grant: got %b expected %b", grant, 9'h001); end
        if (unit_stall !== 9'h1FE) begin errors++; $display("[TB] FAIL allvalid_unit_stall: got %b expected %b", unit_stall, 9'h1FE); end
        if (p_sel !== FDIV_unit) begin errors++; $display("[TB] FAIL allvalid_p_sel: got %0d expected %0d", p_sel, FDIV_unit); end
        drive_cycle(1'b1, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin;
        logic [8:0] exp_grant;
        logic       exp_starved;
        for (int c = 1; c <= 11; c++) begin
            drive_cycle(1'b1, 9'h109, 1'b0, 1'b0);
            exp_grant   = (c == 9) ? 9'h008 : (c == 10) ? 9'h100 : 9'h001;
            exp_starved = (c == 9) || (c == 10);
            checks += 2;
            if (grant !== exp_grant) begin errors++; $display("[TB] FAIL rr_grant cycle %0d: got %b expected %b", c, grant, exp_grant); end
            if (starved !== exp_starved) begin errors++; $display("[TB] FAIL rr_starved cycle %0d: got %b expected %b", c, starved, exp_starved); end
        end
        drive_cycle(1'b1, 9'h000, 1'b0, 1'b0);
    endtask

    initial begin
        clk        = 1'b0;
        reset_n    = 1'b0;
        unit_valid = 9'h000;
        wb_stall   = 1'b0;
        flush      = 1'b0;
        checks     = 0;
        errors     = 0;

        test_reset();
        test_single();
        test_contention();
        test_starvation();
        test_stall();
        test_flush();
        test_valid_drop();
        test_reset_mid();
        test_round_robin();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
